if_id_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, sitting directly upstream of the ID/EX register.
- Owns the PC and issues fetch requests to instruction memory.
- Absorbs memory wait states, decode stalls and branch/jump redirects.
- Delivers {instruction, PC+4, valid} to decode, whose PC+4 feeds the ID/EX pc-add field.
- Contains a one-entry hold buffer so no fetched word is lost while decode is stalled.

---
 rtl/if_id_stage_pkg.sv | 34 +++
 rtl/if_id_stage_hold_buf.sv | 57 +++++
 rtl/if_id_stage.sv | 103 ++++++++++
 tb/tb_if_id_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// +--------------------------------------------------------------------------+
// | if_id_stage_pkg : shared fetch/decode pipeline types and IF/ID layout     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package if_id_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // IF/ID register layout: {valid, instr, pc_add}, shared with decode and ID/EX.
  localparam int unsigned IFID_PCADD_LSB = 0;
  localparam int unsigned IFID_PCADD_MSB = XLEN - 1;
  localparam int unsigned IFID_INSTR_LSB = XLEN;
  localparam int unsigned IFID_INSTR_MSB = XLEN + ILEN - 1;
  localparam int unsigned IFID_VALID_BIT = XLEN + ILEN;
  localparam int unsigned IFID_W         = XLEN + ILEN + 1;

  function automatic logic [IFID_W-1:0] pack_ifid(input logic            valid,
                                                  input logic [ILEN-1:0] instr,
                                                  input logic [XLEN-1:0] pc_add);
    return {valid, instr, pc_add};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_stage_hold_buf.sv
// +--------------------------------------------------------------------------+
// | if_hold_buf : one-entry {instr, pc_add} buffer with full flag             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_hold_buf
  import if_id_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_add_i,
  output logic            full_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_add_o
);

  logic            full_q,   full_d;
  logic [ILEN-1:0] instr_q,  instr_d;
  logic [XLEN-1:0] pc_add_q, pc_add_d;

  // Drain wins over load: a redirect discards whatever arrives with it.
  always_comb begin
    full_d   = full_q;
    instr_d  = instr_q;
    pc_add_d = pc_add_q;
    if (drain_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d   = 1'b1;
      instr_d  = instr_i;
      pc_add_d = pc_add_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 1'b0;
      instr_q  <= NOP;
      pc_add_q <= '0;
    end else begin
      full_q   <= full_d;
      instr_q  <= instr_d;
      pc_add_q <= pc_add_d;
    end
  end

  assign full_o   = full_q;
  assign instr_o  = instr_q;
  assign pc_add_o = pc_add_q;

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
// +--------------------------------------------------------------------------+
// | if_id_stage : PC, instruction fetch FSM and IF/ID pipeline register      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_INC   = 32'd4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_add_out,
  output logic            if_id_valid,
  output logic [31:0]     fetch_count
);

  fetch_state_e      state_q;
  logic [XLEN-1:0]   pc_q;
  logic [IFID_W-1:0] ifid_q;
  logic [31:0]       fetch_count_q;

  logic [XLEN-1:0]   pc_plus;
  logic              buf_load;
  logic              buf_drain;
  logic              buf_full;
  logic [ILEN-1:0]   buf_instr;
  logic [XLEN-1:0]   buf_pc_add;

  assign pc_plus   = pc_q + PC_INC;
  assign buf_load  = !redirect_valid && (state_q == FETCH) && imem_ready && stall;
  assign buf_drain = redirect_valid || ((state_q == HOLD) && !stall);

  if_hold_buf u_hold_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (buf_load),
    .drain_i  (buf_drain),
    .instr_i  (imem_rdata),
    .pc_add_i (pc_plus),
    .full_o   (buf_full),
    .instr_o  (buf_instr),
    .pc_add_o (buf_pc_add)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ifid_q        <= pack_ifid(1'b0, NOP, '0);
      fetch_count_q <= '0;
    end else if (redirect_valid) begin
      state_q                <= FETCH;
      pc_q                   <= redirect_pc;
      ifid_q[IFID_VALID_BIT] <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_q <= pc_plus;
            if (stall) begin
              state_q <= HOLD;
            end else begin
              ifid_q        <= pack_ifid(1'b1, imem_rdata, pc_plus);
              fetch_count_q <= fetch_count_q + 32'd1;
            end
          end else if (!stall) begin
            ifid_q[IFID_VALID_BIT] <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_q        <= pack_ifid(buf_full, buf_instr, buf_pc_add);
            fetch_count_q <= fetch_count_q + 32'd1;
            state_q       <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request is gated by reset_n so it drops the instant reset asserts.
  assign imem_req         = reset_n && (state_q == FETCH);
  assign imem_addr        = pc_q;
  assign if_id_valid      = ifid_q[IFID_VALID_BIT];
  assign if_id_instr      = ifid_q[IFID_INSTR_MSB:IFID_INSTR_LSB];
  assign if_id_pc_add_out = ifid_q[IFID_PCADD_MSB:IFID_PCADD_LSB];
  assign fetch_count      = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// +--------------------------------------------------------------------------+
// | tb_if_id_stage : directed table-driven bench for if_id_stage             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_if_id_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_add_out;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Instruction memory: each word encodes its own low address bits.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  if_id_stage dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .if_id_instr      (if_id_instr),
    .if_id_pc_add_out (if_id_pc_add_out),
    .if_id_valid      (if_id_valid),
    .fetch_count      (fetch_count)
  );

  typedef struct {
    logic        ready;
    logic        stl;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcadd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic st, input logic rd,
                              input logic [31:0] rp, input logic [31:0] ad,
                              input logic rq, input logic v, input logic [31:0] ins,
                              input logic [31:0] pa, input logic [31:0] c);
    vec_t x;
    x.ready = rdy; x.stl = st; x.redir = rd; x.rpc = rp;
    x.e_addr = ad; x.e_req = rq; x.e_valid = v; x.e_instr = ins;
    x.e_pcadd = pa; x.e_cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic req,
                         input logic v, input logic [31:0] ins, input logic [31:0] pa,
                         input logic [31:0] c);
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".pcadd"}, if_id_pc_add_out, pa);
    chk({tag, ".count"}, fetch_count, c);
  endtask

  initial begin
    //                 rdy st rd  rpc            addr          req v  instr          pcadd          cnt
    // zero-wait streaming
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h4,         1, 1, 32'hC0DE_0000, 32'h4,         32'd1));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h8,         1, 1, 32'hC0DE_0004, 32'h8,         32'd2));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'hC,         1, 1, 32'hC0DE_0008, 32'hC,         32'd3));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h10,        1, 1, 32'hC0DE_000C, 32'h10,        32'd4));
    // two wait states at 0x10: bubbles, address held
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h10,        1, 0, 32'hC0DE_000C, 32'h10,        32'd4));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h10,        1, 0, 32'hC0DE_000C, 32'h10,        32'd4));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h14,        1, 1, 32'hC0DE_0010, 32'h14,        32'd5));
    // stall with no response: IF/ID frozen
    vecs.push_back(mk(0, 1, 0, 32'h0,         32'h14,        1, 1, 32'hC0DE_0010, 32'h14,        32'd5));
    // response under stall: buffered, HOLD drops the request
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h18,        0, 1, 32'hC0DE_0010, 32'h14,        32'd5));
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h18,        0, 1, 32'hC0DE_0010, 32'h14,        32'd5));
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h18,        0, 1, 32'hC0DE_0010, 32'h14,        32'd5));
    // stall falls: buffered word delivered, fetch resumes at 0x18
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h18,        1, 1, 32'hC0DE_0014, 32'h18,        32'd6));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h1C,        1, 1, 32'hC0DE_0018, 32'h1C,        32'd7));
    // enter HOLD, then redirect under stall discards buffered word
    vecs.push_back(mk(1, 1, 0, 32'h0,         32'h20,        0, 1, 32'hC0DE_0018, 32'h1C,        32'd7));
    vecs.push_back(mk(1, 1, 1, 32'h40,        32'h40,        1, 0, 32'hC0DE_0018, 32'h1C,        32'd7));
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h44,        1, 1, 32'hC0DE_0040, 32'h44,        32'd8));
    // redirect with same-cycle response: response dropped
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'hC0DE_0040, 32'h44,        32'd8));
    // PC wrap
    vecs.push_back(mk(1, 0, 0, 32'h0,         32'h0,         1, 1, 32'hC0DE_FFFC, 32'h0,         32'd9));
    // redirect overrides stall in FETCH
    vecs.push_back(mk(1, 1, 1, 32'h20,        32'h20,        1, 0, 32'hC0DE_FFFC, 32'h0,         32'd9));
    vecs.push_back(mk(0, 0, 0, 32'h0,         32'h20,        1, 0, 32'hC0DE_FFFC, 32'h0,         32'd9));

    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    reset_n = 1'b1;
    #1;
    chk_all("release", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      imem_ready     = vecs[i].ready;
      stall          = vecs[i].stl;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      @(negedge clock);
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req, vecs[i].e_valid,
              vecs[i].e_instr, vecs[i].e_pcadd, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-wait at 0x20
    imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk_all("rst_release", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clock);
    chk_all("post_rst_fetch", 32'h4, 1'b1, 1'b1, 32'hC0DE_0000, 32'h4, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
